// File: rtl/pipe_pkg.sv
// pipe_pkg: shared lane payload layout and control struct for the pipeline registers
//   Provides field widths/offsets of one lane's packed payload, the derived
//   default payload width, and the control struct reused by IF/ID and EX/MEM.
package pipe_pkg;
    localparam int REG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int IMM_W      = 32;
    localparam int PC_W       = 8;
    localparam int SHAMT_W    = 5;
    localparam int ALUOP_W    = 4;
    localparam int MEMTOREG_W = 2;
    localparam int REGDST_W   = 2;

    typedef struct packed {
        logic [ALUOP_W-1:0]    alu_op;
        logic [MEMTOREG_W-1:0] mem_to_reg;
        logic [REGDST_W-1:0]   reg_dst;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  alu_src;
        logic                  jump;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Fields are packed upward from bit 0 in this order.
    localparam int CTRL_LSB  = 0;
    localparam int SHAMT_LSB = CTRL_LSB + CTRL_W;
    localparam int PC_LSB    = SHAMT_LSB + SHAMT_W;
    localparam int BRPC_LSB  = PC_LSB + PC_W;
    localparam int RT_LSB    = BRPC_LSB + PC_W;
    localparam int RS_LSB    = RT_LSB + REG_W;
    localparam int RD_LSB    = RS_LSB + REG_W;
    localparam int IMM_LSB   = RD_LSB + REG_W;
    localparam int DATA_LSB  = IMM_LSB + IMM_W;
    localparam int USED_W    = DATA_LSB + DATA_W;
    // Spare bits keep the lane a round 128 bits for future fields.
    localparam int SPARE_W   = 14;
    localparam int PAYLOAD_W_DEF = USED_W + SPARE_W;

    function automatic ctrl_t lane_ctrl(input logic [PAYLOAD_W_DEF-1:0] p);
        return ctrl_t'(p[CTRL_LSB +: CTRL_W]);
    endfunction
endpackage

// File: rtl/lane_reg.sv
// lane_reg: one issue lane's valid + payload register with reset > kill > stall priority
//   clk, reset     : clock, synchronous active-high reset
//   stall, kill    : hold this lane / flush this lane (kill wins over stall)
//   in_valid/in_payload   : decode-side lane contents
//   out_valid/out_payload : registered lane contents to execute
module lane_reg #(
    parameter int PAYLOAD_W     = 128,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 kill,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload
);
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else if (kill) begin
            out_valid <= 1'b0;
            if (ZERO_ON_FLUSH) out_payload <= '0;
        end else if (!stall) begin
            out_valid   <= in_valid;
            out_payload <= in_payload;
        end
    end
endmodule

// File: rtl/ex_stage_lane_reg.sv
// ex_stage_lane_reg: multi-lane decode-to-execute pipeline register with flush and perf counters
//   clk, reset       : clock, synchronous active-high reset
//   stall            : hold all lanes
//   flush_all        : flush every lane
//   flush_lane       : per-lane flush (optionally squashing younger lanes)
//   in_valid/in_payload   : decode-side lanes, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   out_valid/out_payload : registered lanes to execute
//   bubble_cnt/flush_cnt  : saturating bubble-slot and flush-cycle counters
//   cnt_clear        : synchronous clear of both counters
module ex_stage_lane_reg import pipe_pkg::*; #(
    parameter int LANES          = 2,
    parameter int PAYLOAD_W      = PAYLOAD_W_DEF,
    parameter bit SQUASH_YOUNGER = 1'b1,
    parameter bit ZERO_ON_FLUSH  = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush_all,
    input  logic [LANES-1:0]           flush_lane,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           flush_cnt,
    input  logic                       cnt_clear
);
    logic [LANES-1:0] kill;
    logic [LANES-1:0] bub;
    logic             older;
    logic [CNT_W:0]   bub_sum;
    logic [CNT_W:0]   flush_sum;

    always_comb begin
        older   = 1'b0;
        kill    = '0;
        bub     = '0;
        bub_sum = {1'b0, bubble_cnt};
        for (int i = 0; i < LANES; i++) begin
            kill[i] = flush_all | flush_lane[i] | (SQUASH_YOUNGER & older);
            older   = older | flush_lane[i];
            // On a stall edge only a kill of a currently valid lane creates a new bubble.
            bub[i]  = kill[i] ? (!stall | out_valid[i]) : (!stall & !in_valid[i]);
            bub_sum = bub_sum + (CNT_W+1)'(bub[i]);
        end
        flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(|kill);
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            bubble_cnt <= bub_sum[CNT_W] ? '1 : bub_sum[CNT_W-1:0];
            flush_cnt  <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_reg #(
            .PAYLOAD_W    (PAYLOAD_W),
            .ZERO_ON_FLUSH(ZERO_ON_FLUSH)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .stall      (stall),
            .kill       (kill[g]),
            .in_valid   (in_valid[g]),
            .in_payload (in_payload[g*PAYLOAD_W +: PAYLOAD_W]),
            .out_valid  (out_valid[g]),
            .out_payload(out_payload[g*PAYLOAD_W +: PAYLOAD_W])
        );
    end
endmodule

// File: tb/tb_ex_stage_lane_reg.sv
// tb_ex_stage_lane_reg: self-checking bench for ex_stage_lane_reg across three configurations
module tb_ex_stage_lane_reg;
    localparam int L = 2;
    localparam int P = 128;
    localparam int W = L * P;
    localparam int OW = L + W + 32;

    logic clk = 1'b0;
    logic reset, stall, flush_all, cnt_clear;
    logic [L-1:0] flush_lane, in_valid;
    logic [W-1:0] in_payload;
    logic [L-1:0] v0, v1, v2;
    logic [W-1:0] p0, p1, p2;
    logic [15:0] b0, f0, b1, f1;
    logic [3:0] b2, f2;

    int checks = 0;
    int errors = 0;

    // Reference state per configuration: 0 default, 1 no-squash/keep-payload, 2 4-bit counters.
    bit mv[3][L];
    logic [P-1:0] mp[3][L];
    int mb[3];
    int mf[3];

    always #5 clk = ~clk;

    ex_stage_lane_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush_all(flush_all), .flush_lane(flush_lane),
        .in_valid(in_valid), .in_payload(in_payload), .out_valid(v0), .out_payload(p0),
        .bubble_cnt(b0), .flush_cnt(f0), .cnt_clear(cnt_clear)
    );
    ex_stage_lane_reg #(.SQUASH_YOUNGER(1'b0), .ZERO_ON_FLUSH(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .stall(stall), .flush_all(flush_all), .flush_lane(flush_lane),
        .in_valid(in_valid), .in_payload(in_payload), .out_valid(v1), .out_payload(p1),
        .bubble_cnt(b1), .flush_cnt(f1), .cnt_clear(cnt_clear)
    );
    ex_stage_lane_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush_all(flush_all), .flush_lane(flush_lane),
        .in_valid(in_valid), .in_payload(in_payload), .out_valid(v2), .out_payload(p2),
        .bubble_cnt(b2), .flush_cnt(f2), .cnt_clear(cnt_clear)
    );

    function automatic bit cfg_sq(int c);
        return c != 1;
    endfunction
    function automatic bit cfg_zero(int c);
        return c != 1;
    endfunction
    function automatic int cfg_max(int c);
        return (c == 2) ? 15 : 65535;
    endfunction

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            int add = 0;
            bit anyk = 0;
            for (int i = 0; i < L; i++) begin
                bit older_flush = (int'(flush_lane) % (1 << i)) != 0;
                bit k = flush_all || flush_lane[i] || (cfg_sq(c) && older_flush);
                if (k) anyk = 1;
                if (reset) begin
                    mv[c][i] = 0;
                    mp[c][i] = '0;
                end else if (k) begin
                    if (!stall || mv[c][i]) add++;
                    mv[c][i] = 0;
                    if (cfg_zero(c)) mp[c][i] = '0;
                end else if (!stall) begin
                    mv[c][i] = in_valid[i];
                    mp[c][i] = in_payload[i*P +: P];
                    if (!in_valid[i]) add++;
                end
            end
            if (reset || cnt_clear) begin
                mb[c] = 0;
                mf[c] = 0;
            end else begin
                mb[c] = (mb[c] + add > cfg_max(c)) ? cfg_max(c) : mb[c] + add;
                mf[c] = (mf[c] + int'(anyk) > cfg_max(c)) ? cfg_max(c) : mf[c] + int'(anyk);
            end
        end
    endtask

    function automatic logic [OW-1:0] expv(int c);
        return {mv[c][1], mv[c][0], mp[c][1], mp[c][0], 16'(mb[c]), 16'(mf[c])};
    endfunction

    function automatic logic [OW-1:0] obs(int c);
        if (c == 0) return {v0, p0, b0, f0};
        if (c == 1) return {v1, p1, b1, f1};
        return {v2, p2, 12'b0, b2, 12'b0, f2};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; flush_all = 0; flush_lane = '0; cnt_clear = 0;
        in_valid = '0; in_payload = '0;
    endtask

    function automatic logic [W-1:0] rand_payload();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1; in_valid = 2'b11; in_payload = rand_payload() | 256'h1;
        tick();
        reset = 0;
        checks++;
        if (v0 !== 2'b00 || p0 !== '0 || b0 !== 16'd0 || f0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_dut got v=%b b=%0d f=%0d p=%h need v=00 b=0 f=0 p=0", v0, b0, f0, p0);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== expv(c)) begin
                errors++;
                $display("FAIL reset_model cfg%0d got %h need %h", c, obs(c), expv(c));
            end
        end
    endtask

    task automatic test_pass_through();
        int pre;
        idle_inputs();
        pre = mb[0];
        in_valid = 2'b11;
        in_payload = {{16{8'h3C}}, {16{8'hA5}}};
        tick();
        checks++;
        if (v0 !== 2'b11 || p0 !== {{16{8'h3C}}, {16{8'hA5}}} || int'(b0) != pre) begin
            errors++;
            $display("FAIL pass_through got v=%b b=%0d p=%h need v=11 b=%0d", v0, b0, p0, pre);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== expv(c)) begin
                errors++;
                $display("FAIL pass_model cfg%0d got %h need %h", c, obs(c), expv(c));
            end
        end
    endtask

    task automatic test_stall_hold();
        logic [W-1:0] held;
        idle_inputs();
        in_valid = 2'b11;
        held = rand_payload();
        in_payload = held;
        tick();
        stall = 1;
        for (int n = 0; n < 3; n++) begin
            in_valid = 2'(n);
            in_payload = rand_payload();
            tick();
            checks++;
            if (v0 !== 2'b11 || p0 !== held) begin
                errors++;
                $display("FAIL stall_hold cyc%0d got v=%b p=%h need v=11 p=%h", n, v0, p0, held);
            end
        end
        stall = 0;
        in_valid = 2'b01;
        in_payload = rand_payload();
        held = in_payload;
        tick();
        checks++;
        if (v0 !== 2'b01 || p0 !== held) begin
            errors++;
            $display("FAIL stall_release got v=%b p=%h need v=01 p=%h", v0, p0, held);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== expv(c)) begin
                errors++;
                $display("FAIL stall_model cfg%0d got %h need %h", c, obs(c), expv(c));
            end
        end
    endtask

    task automatic test_squash_younger();
        int pre_b, pre_f;
        idle_inputs();
        in_valid = 2'b11;
        in_payload = rand_payload();
        tick();
        pre_b = mb[0];
        pre_f = mf[0];
        flush_lane = 2'b01;
        tick();
        checks++;
        if (v0 !== 2'b00 || p0 !== '0 || int'(b0) != pre_b + 2 || int'(f0) != pre_f + 1) begin
            errors++;
            $display("FAIL squash_on got v=%b b=%0d f=%0d need v=00 b=%0d f=%0d p=0",
                     v0, b0, f0, pre_b + 2, pre_f + 1);
        end
        checks++;
        if (v1 !== 2'b10) begin
            errors++;
            $display("FAIL squash_off got v=%b need 10", v1);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== expv(c)) begin
                errors++;
                $display("FAIL squash_model cfg%0d got %h need %h", c, obs(c), expv(c));
            end
        end
    endtask

    task automatic test_flush_over_stall();
        int pre_b;
        logic [W-1:0] held;
        idle_inputs();
        in_valid = 2'b11;
        held = rand_payload();
        in_payload = held;
        tick();
        pre_b = mb[0];
        stall = 1;
        flush_lane = 2'b10;
        in_payload = rand_payload();
        tick();
        checks++;
        if (v0 !== 2'b01 || p0[P-1:0] !== held[P-1:0] || p0[W-1:P] !== '0 || int'(b0) != pre_b + 1) begin
            errors++;
            $display("FAIL flush_over_stall got v=%b b=%0d p=%h need v=01 b=%0d lane0=%h",
                     v0, b0, p0, pre_b + 1, held[P-1:0]);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== expv(c)) begin
                errors++;
                $display("FAIL fos_model cfg%0d got %h need %h", c, obs(c), expv(c));
            end
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        in_payload = rand_payload();
        for (int n = 0; n < 20; n++) tick();
        checks++;
        if (b2 !== 4'hF) begin
            errors++;
            $display("FAIL sat_bubble got %0d need 15", b2);
        end
        tick();
        checks++;
        if (b2 !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold got %0d need 15", b2);
        end
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        checks++;
        if (b2 !== 4'h0 || f2 !== 4'h0 || b0 !== 16'd0) begin
            errors++;
            $display("FAIL sat_clear got b=%0d f=%0d b_wide=%0d need 0 0 0", b2, f2, b0);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== expv(c)) begin
                errors++;
                $display("FAIL sat_model cfg%0d got %h need %h", c, obs(c), expv(c));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom % 40) == 0;
            stall      = ($urandom % 4) == 0;
            flush_all  = ($urandom % 16) == 0;
            flush_lane = (($urandom % 5) == 0) ? 2'($urandom) : 2'b00;
            cnt_clear  = ($urandom % 60) == 0;
            in_valid   = 2'($urandom);
            in_payload = rand_payload();
            tick();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (obs(c) !== expv(c)) begin
                    errors++;
                    $display("FAIL random n%0d cfg%0d got %h need %h", n, c, obs(c), expv(c));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_pass_through();
        test_stall_hold();
        test_squash_younger();
        test_flush_over_stall();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
